// File: rtl/axil_host_master.sv
// AXI4-Lite initiator: one 64-bit register command at a time, written as two
// 32-bit-strobed beats (lower, then committing upper) or read as one 64-bit beat.
//
// Handshake contract: every channel transfers on a cycle where VALID && READY at the
// rising clock edge. Our VALIDs are decoded from registered state only (never from
// READY), and ADDR/DATA/STRB are held until the matching READY. cmd_valid/cmd_ready
// follow the same rule. rsp_valid is a one-cycle pulse with no backpressure.
module axil_host_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_LO  = 3'd1,
    B_LO  = 3'd2,
    W_HI  = 3'd3,
    B_HI  = 3'd4,
    RD_A  = 3'd5,
    RD_R  = 3'd6,
    DRAIN = 3'd7
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [28:0]   addr_q, addr_d;      // 8-byte-aligned address, bits [31:3]
  logic [63:0]   wdata_q, wdata_d;
  logic          write_q, write_d;    // also selects BREADY vs RREADY in DRAIN
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [63:0]   rsp_rdata_q, rsp_rdata_d;

  logic in_w, hi_beat, aw_hs, w_hs;

  assign in_w    = (state_q == W_LO) || (state_q == W_HI);
  assign hi_beat = (state_q == W_HI);

  assign cmd_ready     = (state_q == IDLE) && !M_AXI_ARESET;
  assign M_AXI_AWVALID = in_w && !aw_done_q;
  assign M_AXI_WVALID  = in_w && !w_done_q;
  assign M_AXI_AWADDR  = {addr_q, hi_beat, 2'b00};
  assign M_AXI_WSTRB   = hi_beat ? 8'hf0 : 8'h0f;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_BREADY  = (state_q == B_LO) || (state_q == B_HI) || ((state_q == DRAIN) && write_q);
  assign M_AXI_ARVALID = (state_q == RD_A);
  assign M_AXI_ARADDR  = {addr_q, 3'b000};
  assign M_AXI_RREADY  = (state_q == RD_R) || ((state_q == DRAIN) && !write_q);

  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign dbg_state_o = state_q;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    tmo_d       = tmo_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr[31:3];
          wdata_d   = cmd_wdata;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? W_LO : RD_A;
        end
      end

      // AW and W complete independently; leave once both have handshaken.
      W_LO, W_HI: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = (state_q == W_LO) ? B_LO : B_HI;
          tmo_d   = '0;
        end
      end

      // A failed lower beat skips the upper one so the slave never commits.
      B_LO, B_HI: begin
        if (M_AXI_BVALID) begin
          if ((state_q == B_LO) && (M_AXI_BRESP == 2'b00)) begin
            state_d   = W_HI;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = (M_AXI_BRESP != 2'b00);
            rsp_rdata_d = '0;
            state_d     = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RD_A: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_R;
          tmo_d   = '0;
        end
      end

      RD_R: begin
        if (M_AXI_RVALID) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = (M_AXI_RRESP != 2'b00);
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // Swallow the late response so it cannot be mistaken for the next command's.
      DRAIN: begin
        if (write_q ? M_AXI_BVALID : M_AXI_RVALID) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_host_master.sv
// Directed bench for axil_host_master: one task per scenario, inline checks,
// inputs driven and outputs sampled 1 ns after each rising edge.
module tb_axil_host_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [31:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_host_master #(.TIMEOUT(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .dbg_state_o(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single edge; caller has made sure cmd_ready is high.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    n_checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin n_fail++; $display("FAIL rst_axi_valid_ready got=%b exp=00000", {awvalid, wvalid, bready, arvalid, rready}); end
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp got=%b exp=00", {rsp_valid, rsp_err}); end
    n_checks++; if (rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    n_checks++; if (awaddr !== 32'h0) begin n_fail++; $display("FAIL rst_awaddr got=%h exp=0", awaddr); end
    rst = 1'b0;
    step();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  // Fully ready slave: BVALID answers BREADY on the next edge.
  task automatic test_write_basic();
    logic [31:0] a_seen [2];
    logic [7:0]  s_seen [2];
    logic [63:0] d_seen [2];
    int nb = 0;
    int cyc;
    awready = 1'b1; wready = 1'b1; bresp = 2'b00;
    issue(1'b1, 32'h0000_1008, 64'h1122334455667788);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      if (awvalid === 1'b1 && nb < 2) begin
        a_seen[nb] = awaddr; s_seen[nb] = wstrb; d_seen[nb] = wdata; nb++;
      end
      bvalid = bready;
      step();
      cyc++;
    end
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    // W_LO, B_LO, W_HI, B_HI, then rsp: five cycles after the accept cycle.
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL wr_latency got=%0d exp=5", cyc); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", rsp_err); end
    n_checks++; if (rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL wr_rdata got=%h exp=0", rsp_rdata); end
    n_checks++; if (nb !== 2) begin n_fail++; $display("FAIL wr_beats got=%0d exp=2", nb); end
    n_checks++; if ({a_seen[0], s_seen[0]} !== {32'h1008, 8'h0f}) begin n_fail++; $display("FAIL wr_beat0 got=%h/%h exp=00001008/0f", a_seen[0], s_seen[0]); end
    n_checks++; if ({a_seen[1], s_seen[1]} !== {32'h100c, 8'hf0}) begin n_fail++; $display("FAIL wr_beat1 got=%h/%h exp=0000100c/f0", a_seen[1], s_seen[1]); end
    n_checks++; if (d_seen[0] !== 64'h1122334455667788 || d_seen[1] !== 64'h1122334455667788) begin n_fail++; $display("FAIL wr_wdata got=%h/%h exp=1122334455667788", d_seen[0], d_seen[1]); end
    step();
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_after got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_handshake_order();
    int extra = 0;
    awready = 1'b0; wready = 1'b1;
    issue(1'b1, 32'h0000_1008, 64'h1122334455667788);
    n_checks++; if ({awvalid, wvalid, awaddr, wstrb} !== {2'b11, 32'h1008, 8'h0f}) begin n_fail++; $display("FAIL ho_lo_start got=%b%b %h %h exp=11 00001008 0f", awvalid, wvalid, awaddr, wstrb); end
    step(); wready = 1'b0;
    n_checks++; if ({awvalid, wvalid} !== 2'b10) begin n_fail++; $display("FAIL ho_w_drop got=%b exp=10", {awvalid, wvalid}); end
    step();
    n_checks++; if (awvalid !== 1'b1 || awaddr !== 32'h1008) begin n_fail++; $display("FAIL ho_aw_hold got=%b %h exp=1 00001008", awvalid, awaddr); end
    step(); awready = 1'b1;
    step(); awready = 1'b0;
    n_checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin n_fail++; $display("FAIL ho_b_lo got=%b exp=001", {awvalid, wvalid, bready}); end
    bvalid = 1'b1;
    step(); bvalid = 1'b0;
    n_checks++; if ({awvalid, wvalid, awaddr, wstrb} !== {2'b11, 32'h100c, 8'hf0}) begin n_fail++; $display("FAIL ho_hi_start got=%b%b %h %h exp=11 0000100c f0", awvalid, wvalid, awaddr, wstrb); end
    awready = 1'b1;
    step(); awready = 1'b0;
    n_checks++; if ({awvalid, wvalid} !== 2'b01) begin n_fail++; $display("FAIL ho_aw_drop got=%b exp=01", {awvalid, wvalid}); end
    step(); wready = 1'b1;
    n_checks++; if (wvalid !== 1'b1 || wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL ho_w_hold got=%b %h exp=1 1122334455667788", wvalid, wdata); end
    step(); wready = 1'b0;
    n_checks++; if ({wvalid, bready} !== 2'b01) begin n_fail++; $display("FAIL ho_b_hi got=%b exp=01", {wvalid, bready}); end
    bvalid = 1'b1;
    step(); bvalid = 1'b0;
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL ho_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ho_single_rsp got=%0d extra exp=0", extra); end
  endtask

  task automatic test_read();
    int early = 0;
    issue(1'b0, 32'h0000_2000, 64'h0);
    n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h2000}) begin n_fail++; $display("FAIL rd_ar got=%b %h exp=1 00002000", arvalid, araddr); end
    step();
    step(); arready = 1'b1;
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_ar_hold got=%b exp=1", arvalid); end
    step(); arready = 1'b0;
    n_checks++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL rd_r_wait got=%b exp=01", {arvalid, rready}); end
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) early++;
      step();
    end
    rvalid = 1'b1; rdata = 64'hDEADBEEF_CAFEF00D; rresp = 2'b00;
    step(); rvalid = 1'b0; rdata = 64'h0;
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL rd_early_rsp got=%0d exp=0", early); end
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL rd_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    n_checks++; if (rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL rd_rdata got=%h exp=deadbeefcafef00d", rsp_rdata); end
    step();
  endtask

  task automatic test_bresp_err();
    int aw_seen = 0;
    int rsp_seen = 0;
    awready = 1'b1; wready = 1'b1;
    issue(1'b1, 32'h0000_3010, 64'hA5A5_0000_5A5A_FFFF);
    step();
    n_checks++; if (bready !== 1'b1) begin n_fail++; $display("FAIL be_bready got=%b exp=1", bready); end
    bvalid = 1'b1; bresp = 2'b10;
    step(); bvalid = 1'b0; bresp = 2'b00;
    n_checks++; if ({rsp_valid, rsp_err, cmd_ready, awvalid} !== 4'b1110) begin n_fail++; $display("FAIL be_rsp got=%b exp=1110", {rsp_valid, rsp_err, cmd_ready, awvalid}); end
    for (int i = 0; i < 5; i++) begin
      step();
      if (awvalid === 1'b1) aw_seen++;
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    awready = 1'b0; wready = 1'b0;
    n_checks++; if ({aw_seen, rsp_seen} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL be_no_upper got=%0d/%0d exp=0/0", aw_seen, rsp_seen); end
  endtask

  task automatic test_timeout();
    int first_rsp = -1;
    int nrsp = 0;
    int bad_ready = 0;
    int bad_bready = 0;
    logic tmo_err = 1'b0;
    logic [63:0] tmo_rdata = '1;
    awready = 1'b1; wready = 1'b1;
    issue(1'b1, 32'h0000_4000, 64'h0123);
    step(); awready = 1'b0; wready = 1'b0;
    n_checks++; if (dbg_state !== 3'd2) begin n_fail++; $display("FAIL to_in_b_lo got=%0d exp=2", dbg_state); end
    for (int k = 0; k <= 40; k++) begin
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (first_rsp < 0) first_rsp = k;
        tmo_err = rsp_err; tmo_rdata = rsp_rdata;
      end
      if (cmd_ready !== 1'b0) bad_ready++;
      if (bready !== 1'b1) bad_bready++;
      if (k == 40) bvalid = 1'b1;
      step();
    end
    bvalid = 1'b0;
    n_checks++; if (first_rsp !== 16) begin n_fail++; $display("FAIL to_cycle got=%0d exp=16", first_rsp); end
    n_checks++; if (nrsp !== 1) begin n_fail++; $display("FAIL to_rsp_count got=%0d exp=1", nrsp); end
    n_checks++; if ({tmo_err, tmo_rdata} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL to_err_rdata got=%b %h exp=1 0", tmo_err, tmo_rdata); end
    n_checks++; if ({bad_ready, bad_bready} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL to_drain_ready got=%0d/%0d exp=0/0", bad_ready, bad_bready); end
    n_checks++; if ({rsp_valid, cmd_ready, dbg_state} !== {2'b01, 3'd0}) begin n_fail++; $display("FAIL to_after_drain got=%b%b %0d exp=01 0", rsp_valid, cmd_ready, dbg_state); end
  endtask

  task automatic test_reset_mid();
    awready = 1'b1; wready = 1'b1;
    issue(1'b1, 32'h0000_5000, 64'h77);
    step(); awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1;
    step(); bvalid = 1'b0;
    n_checks++; if ({awvalid, dbg_state} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL rm_in_w_hi got=%b %0d exp=1 3", awvalid, dbg_state); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({awvalid, wvalid, bready, rsp_valid, cmd_ready} !== 5'b0) begin n_fail++; $display("FAIL rm_async_clear got=%b exp=00000", {awvalid, wvalid, bready, rsp_valid, cmd_ready}); end
    step();
    step(); rst = 1'b0;
    step();
    n_checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rm_release got=%b exp=10", {cmd_ready, rsp_valid}); end
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; rdata = 64'h0123456789ABCDEF;
    issue(1'b0, 32'h0000_2003, 64'h0);
    n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h2000}) begin n_fail++; $display("FAIL rm_read_ar got=%b %h exp=1 00002000", arvalid, araddr); end
    step(); arready = 1'b0;
    step(); rvalid = 1'b0; rdata = 64'h0;
    n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 64'h0123456789ABCDEF}) begin n_fail++; $display("FAIL rm_read_rsp got=%b%b %h exp=10 0123456789abcdef", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 64'hAAAA_0000_1111_2222;
    issue(1'b0, 32'h0000_0040, 64'h0);
    step();
    step();
    n_checks++; if ({rsp_valid, rsp_err, cmd_ready, rsp_rdata} !== {3'b111, 64'hAAAA_0000_1111_2222}) begin n_fail++; $display("FAIL bb_first got=%b%b%b %h exp=111 aaaa000011112222", rsp_valid, rsp_err, cmd_ready, rsp_rdata); end
    rresp = 2'b00; rdata = 64'h5555_6666_7777_8888;
    issue(1'b0, 32'h0000_0048, 64'h0);
    n_checks++; if ({arvalid, araddr, rsp_valid} !== {1'b1, 32'h48, 1'b0}) begin n_fail++; $display("FAIL bb_accept got=%b %h %b exp=1 00000048 0", arvalid, araddr, rsp_valid); end
    step();
    step(); arready = 1'b0; rvalid = 1'b0; rdata = 64'h0;
    n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 64'h5555_6666_7777_8888}) begin n_fail++; $display("FAIL bb_second got=%b%b %h exp=10 5555666677778888", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    test_reset();
    test_write_basic();
    test_handshake_order();
    test_read();
    test_bresp_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
